// File: rtl/seq_detector_param.sv
// Parametrised Moore serial pattern detector with runtime-reloadable pattern/overlap
// mode, valid-qualified input and a saturating match counter.
module seq_detector_param #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1101,
  parameter logic             DEFAULT_OVL = 1'b0,
  localparam int              PROG_W      = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              cfg_load,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              clear_cnt,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              count_sat,
  output logic [PROG_W-1:0] progress
);

  localparam logic [PROG_W-1:0] MATCH_ST = PROG_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  pattern_q;
  logic [PAT_W-1:0]  history_q;
  logic              overlap_q;
  logic [PROG_W-1:0] state_q;
  logic [PROG_W-1:0] state_d;
  logic [PAT_W-1:0]  cand;
  int                k_eff;
  logic              enter_match;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= '0;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      pattern_q <= DEFAULT_PAT;
      overlap_q <= DEFAULT_OVL;
      history_q <= '0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      overlap_q <= cfg_overlap;
      history_q <= '0;
    end else if (in_valid) begin
      history_q <= {history_q[PAT_W-2:0], in_bit};
    end
  end

  // Next state: longest suffix of (last k bits + new bit) that equals a pattern
  // prefix, found by comparing every suffix length against the matching prefix.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cand    = {history_q[PAT_W-2:0], in_bit};
    k_eff   = 0;
    if (cfg_load) begin
      state_d = '0;
    end else if (state_q > MATCH_ST) begin
      state_d = '0;  // unreachable encodings recover to P0
    end else if (in_valid) begin
      k_eff   = (state_q == MATCH_ST && !overlap_q) ? 0 : int'(state_q);
      state_d = '0;
      for (int j = 1; j <= PAT_W; j++) begin
        if (j <= k_eff + 1 &&
            ((cand ^ (pattern_q >> (PAT_W - j))) & ({PAT_W{1'b1}} >> (PAT_W - j))) == '0)
          state_d = PROG_W'(j);
      end
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    match    = (state_q == MATCH_ST);
    progress = state_q;
  end

  assign enter_match = in_valid && !cfg_load && (state_d == MATCH_ST);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (clear_cnt) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (enter_match) begin
      if (match_count != CNT_MAX)            match_count <= match_count + 1'b1;
      if (match_count >= CNT_MAX - 1'b1)     count_sat   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: two detector instances (default and PAT_W=2/CNT_W=2) checked
// every cycle against a string-matching reference model, directed then random stimulus.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic       v0, b0, ld0, co0, cl0;
  logic [3:0] cp0;
  logic       m0, sat0;
  logic [7:0] cnt0;
  logic [2:0] pg0;

  logic       v1, b1, ld1, co1, cl1;
  logic [1:0] cp1;
  logic       m1, sat1;
  logic [1:0] cnt1;
  logic [1:0] pg1;

  seq_detector_param u_dut0 (
    .clk(clk), .arstn(arstn), .in_valid(v0), .in_bit(b0), .cfg_load(ld0),
    .cfg_pattern(cp0), .cfg_overlap(co0), .clear_cnt(cl0), .match(m0),
    .match_count(cnt0), .count_sat(sat0), .progress(pg0)
  );

  seq_detector_param #(
    .PAT_W(2), .CNT_W(2), .DEFAULT_PAT(2'b11), .DEFAULT_OVL(1'b1)
  ) u_dut1 (
    .clk(clk), .arstn(arstn), .in_valid(v1), .in_bit(b1), .cfg_load(ld1),
    .cfg_pattern(cp1), .cfg_overlap(co1), .clear_cnt(cl1), .match(m1),
    .match_count(cnt1), .count_sat(sat1), .progress(pg1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a window of recently accepted bits since the last restart;
  // progress is the longest window suffix that is a prefix of the pattern.
  int mpw[2]   = '{4, 2};
  int mcmax[2] = '{255, 3};
  int mpat[2], mprog[2], mcnt[2], wval[2], wlen[2];
  bit movl[2], msat[2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpat[0] = 13; mpat[1] = 3;
    movl[0] = 1'b0; movl[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mprog[i] = 0; mcnt[i] = 0; msat[i] = 1'b0; wval[i] = 0; wlen[i] = 0;
    end
  endtask

  function automatic int model_prog(int id);
    int best = 0;
    for (int j = 1; j <= wlen[id]; j++) begin
      int msk = (1 << j) - 1;
      if ((wval[id] & msk) == ((mpat[id] >> (mpw[id] - j)) & msk)) best = j;
    end
    return best;
  endfunction

  task automatic model_step(int id, bit v, bit b, bit ld, int cp, bit co, bit cl);
    bit entry;
    entry = 1'b0;
    if (ld) begin
      mpat[id] = cp; movl[id] = co; wval[id] = 0; wlen[id] = 0; mprog[id] = 0;
    end else if (v) begin
      if (mprog[id] == mpw[id] && !movl[id]) begin wval[id] = 0; wlen[id] = 0; end
      wval[id]  = ((wval[id] << 1) | int'(b)) & ((1 << mpw[id]) - 1);
      wlen[id]  = (wlen[id] < mpw[id]) ? wlen[id] + 1 : mpw[id];
      mprog[id] = model_prog(id);
      entry     = (mprog[id] == mpw[id]);
    end
    if (cl) begin
      mcnt[id] = 0; msat[id] = 1'b0;
    end else if (entry) begin
      if (mcnt[id] < mcmax[id]) mcnt[id]++;
      if (mcnt[id] == mcmax[id]) msat[id] = 1'b1;
    end
  endtask

  task automatic check_all(string ph);
    check({ph, "/match0"}, 32'(m0),   32'(mprog[0] == 4));
    check({ph, "/prog0"},  32'(pg0),  32'(mprog[0]));
    check({ph, "/cnt0"},   32'(cnt0), 32'(mcnt[0]));
    check({ph, "/sat0"},   32'(sat0), 32'(msat[0]));
    check({ph, "/match1"}, 32'(m1),   32'(mprog[1] == 2));
    check({ph, "/prog1"},  32'(pg1),  32'(mprog[1]));
    check({ph, "/cnt1"},   32'(cnt1), 32'(mcnt[1]));
    check({ph, "/sat1"},   32'(sat1), 32'(msat[1]));
  endtask

  string phase = "init";

  // Model advances on the same edge as the DUTs; outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (arstn) begin
      model_step(0, v0, b0, ld0, int'(cp0), co0, cl0);
      model_step(1, v1, b1, ld1, int'(cp1), co1, cl1);
    end
    #1;
    check_all(phase);
  endtask

  task automatic send0(bit b); v0 = 1'b1; b0 = b; cycle(); v0 = 1'b0; endtask
  task automatic send1(bit b); v1 = 1'b1; b1 = b; cycle(); v1 = 1'b0; endtask
  task automatic load0(logic [3:0] p, bit o);
    ld0 = 1'b1; cp0 = p; co0 = o; cycle(); ld0 = 1'b0;
  endtask

  initial begin
    // NOTE: stimulus is driven with blocking assignments well away from the clock edge.
    {v0, b0, ld0, co0, cl0, cp0} = '0;
    {v1, b1, ld1, co1, cl1, cp1} = '0;
    model_reset();
    #2;
    check("rst/match0", 32'(m0),   32'd0);
    check("rst/cnt0",   32'(cnt0), 32'd0);
    check("rst/prog0",  32'(pg0),  32'd0);
    check("rst/sat0",   32'(sat0), 32'd0);
    check("rst/prog1",  32'(pg1),  32'd0);
    @(negedge clk);
    arstn = 1'b1;

    phase = "nonovl";
    send0(1); send0(1); send0(0); send0(1);
    check("nonovl/match_after4", 32'(m0), 32'd1);
    send0(1); send0(0); send0(1);
    check("nonovl/cnt", 32'(cnt0), 32'd1);
    check("nonovl/nomatch", 32'(m0), 32'd0);

    phase = "ovl";
    load0(4'b1101, 1'b1);
    check("ovl/prog_after_load", 32'(pg0), 32'd0);
    send0(1); send0(1); send0(0); send0(1); send0(1); send0(0); send0(1);
    check("ovl/cnt", 32'(cnt0), 32'd3);

    phase = "p0111";
    load0(4'b0111, 1'b1);
    send0(0); send0(1); send0(1); send0(1); send0(1); send0(1);
    check("p0111/cnt_single", 32'(cnt0), 32'd4);
    send0(1); send0(0);
    check("p0111/recover_p1", 32'(pg0), 32'd1);
    send0(1); send0(1); send0(1);
    check("p0111/match", 32'(m0), 32'd1);
    check("p0111/cnt", 32'(cnt0), 32'd5);

    phase = "gaps";
    load0(4'b1101, 1'b0);
    cl0 = 1'b1; cycle(); cl0 = 1'b0;
    check("gaps/cleared", 32'(cnt0), 32'd0);
    send0(1); repeat (3) cycle();
    send0(1); repeat (3) cycle();
    send0(0); repeat (3) cycle();
    check("gaps/prog_held", 32'(pg0), 32'd3);
    send0(1);
    repeat (3) begin
      cycle();
      check("gaps/match_held", 32'(m0), 32'd1);
    end
    check("gaps/cnt_once", 32'(cnt0), 32'd1);

    phase = "sat";
    repeat (6) send1(1);
    check("sat/cnt", 32'(cnt1), 32'd3);
    check("sat/flag", 32'(sat1), 32'd1);
    cl1 = 1'b1; cycle(); cl1 = 1'b0;
    check("sat/clr_cnt", 32'(cnt1), 32'd0);
    check("sat/clr_flag", 32'(sat1), 32'd0);
    cl1 = 1'b1; v1 = 1'b1; b1 = 1'b1; cycle(); cl1 = 1'b0; v1 = 1'b0;
    check("sat/clr_wins_match", 32'(m1), 32'd1);
    check("sat/clr_wins_cnt", 32'(cnt1), 32'd0);

    phase = "midrst";
    send0(1); send0(1); send0(0);
    #2 arstn = 1'b0;
    model_reset();
    #1;
    check("midrst/prog0", 32'(pg0),  32'd0);
    check("midrst/cnt0",  32'(cnt0), 32'd0);
    check("midrst/prog1", 32'(pg1),  32'd0);
    @(negedge clk);
    arstn = 1'b1;
    send0(1);
    check("midrst/prog_p1", 32'(pg0), 32'd1);
    check("midrst/nomatch", 32'(m0), 32'd0);
    ld0 = 1'b1; cp0 = 4'b1101; co0 = 1'b0; v0 = 1'b1; b0 = 1'b1;
    cycle();
    ld0 = 1'b0; v0 = 1'b0;
    check("midrst/load_discards", 32'(pg0), 32'd0);

    phase = "rand";
    repeat (3000) begin
      v0  = ($urandom_range(0, 9) < 7);
      b0  = 1'($urandom);
      ld0 = ($urandom_range(0, 49) == 0);
      cp0 = 4'($urandom);
      co0 = 1'($urandom);
      cl0 = ($urandom_range(0, 99) == 0);
      v1  = ($urandom_range(0, 9) < 7);
      b1  = 1'($urandom);
      ld1 = ($urandom_range(0, 49) == 0);
      cp1 = 2'($urandom);
      co1 = 1'($urandom);
      cl1 = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
